// File: rtl/demux_pkg.sv
// demux_pkg -- constants and types shared by the 8-channel demultiplexer.
//   LARGURA    : data width per channel
//   NUM_CANAIS : number of output channels
//   SEL_W      : selector width, log2(NUM_CANAIS)
//   estado_t   : one-entry channel buffer state (VAZIO / CHEIO)
package demux_pkg;

    localparam int LARGURA    = 8;
    localparam int NUM_CANAIS = 8;
    localparam int SEL_W      = $clog2(NUM_CANAIS);

    typedef enum logic {
        VAZIO = 1'b0,
        CHEIO = 1'b1
    } estado_t;

endpackage

// File: rtl/canal_buffer.sv
// canal_buffer -- one-entry output buffer for a single demux channel.
// Ports:
//   clk, rst_n    : clock, synchronous active-low reset
//   carrega       : input transfer addressed to this channel (already qualified)
//   dado_in       : byte to load
//   dado_out      : held byte, stable while valida=1 and pronta=0
//   valida        : buffer is CHEIO
//   pronta        : consumer ready; valida & pronta is an output transfer
// The top only raises carrega when the buffer is empty or draining this
// cycle, so a load while CHEIO always coincides with an output transfer.
module canal_buffer
    import demux_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         carrega,
    input  logic [W-1:0] dado_in,
    output logic [W-1:0] dado_out,
    output logic         valida,
    input  logic         pronta
);

    estado_t      estado, prox;
    logic [W-1:0] dado;

    // state register
    always_ff @(posedge clk) begin
        if (!rst_n) estado <= VAZIO;
        else        estado <= prox;
    end

    // next state: a simultaneous drain and load keeps the buffer full
    always_comb begin
        prox = estado;
        case (estado)
            VAZIO: if (carrega)            prox = CHEIO;
            CHEIO: if (pronta && !carrega) prox = VAZIO;
            default:                       prox = VAZIO;
        endcase
    end

    // outputs
    always_comb begin
        valida = (estado == CHEIO);
    end

    always_ff @(posedge clk) begin
        if (!rst_n)       dado <= '0;
        else if (carrega) dado <= dado_in;
    end

    assign dado_out = dado;

endmodule

// File: rtl/demux_8_canais.sv
// demux_8_canais -- routes a valid/ready byte stream to one of NUM_CANAIS
// independently flow-controlled output channels.
// Ports:
//   clk, rst_n      : clock, synchronous active-low reset
//   entrada         : input byte
//   seletor         : destination channel, sampled with entrada
//   entrada_valida  : entrada/seletor valid
//   entrada_pronta  : input accepted this cycle (combinational)
//   habilita        : per-channel enable; traffic to a disabled channel is dropped
//   saidas          : packed outputs, channel k at [k*LARGURA +: LARGURA]
//   saida_valida    : per-channel data valid
//   saida_pronta    : per-channel consumer ready
//   descartes       : saturating count of dropped bytes
module demux_8_canais #(
    parameter int  LARGURA    = demux_pkg::LARGURA,
    parameter int  NUM_CANAIS = demux_pkg::NUM_CANAIS,
    localparam int SEL_W      = $clog2(NUM_CANAIS)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [LARGURA-1:0]            entrada,
    input  logic [SEL_W-1:0]              seletor,
    input  logic                          entrada_valida,
    output logic                          entrada_pronta,
    input  logic [NUM_CANAIS-1:0]         habilita,
    output logic [NUM_CANAIS*LARGURA-1:0] saidas,
    output logic [NUM_CANAIS-1:0]         saida_valida,
    input  logic [NUM_CANAIS-1:0]         saida_pronta,
    output logic [7:0]                    descartes
);

    logic                  hab_sel;
    logic                  livre_sel;
    logic                  aceita;
    logic [NUM_CANAIS-1:0] carrega;

    // Only the addressed channel gates readiness, so a stalled channel
    // never blocks traffic to the others. Disabled channels always accept.
    assign hab_sel        = habilita[seletor];
    assign livre_sel      = ~saida_valida[seletor] | saida_pronta[seletor];
    assign entrada_pronta = ~hab_sel | livre_sel;
    assign aceita         = entrada_valida & entrada_pronta;

    for (genvar k = 0; k < NUM_CANAIS; k++) begin : g_canal
        assign carrega[k] = aceita & habilita[k] & (seletor == SEL_W'(k));

        canal_buffer #(.W(LARGURA)) u_canal (
            .clk      (clk),
            .rst_n    (rst_n),
            .carrega  (carrega[k]),
            .dado_in  (entrada),
            .dado_out (saidas[k*LARGURA +: LARGURA]),
            .valida   (saida_valida[k]),
            .pronta   (saida_pronta[k])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            descartes <= '0;
        else if (aceita && !hab_sel && descartes != 8'hFF)
            descartes <= descartes + 8'd1;
    end

endmodule

// File: tb/tb_demux_8_canais.sv
module tb_demux_8_canais;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  entrada;
    logic [2:0]  seletor;
    logic        entrada_valida;
    logic        entrada_pronta;
    logic [7:0]  habilita;
    logic [63:0] saidas;
    logic [7:0]  saida_valida;
    logic [7:0]  saida_pronta;
    logic [7:0]  descartes;

    int checks   = 0;
    int failures = 0;

    logic [7:0] expq [8][$];

    always #5 clk = ~clk;

    demux_8_canais dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .entrada        (entrada),
        .seletor        (seletor),
        .entrada_valida (entrada_valida),
        .entrada_pronta (entrada_pronta),
        .habilita       (habilita),
        .saidas         (saidas),
        .saida_valida   (saida_valida),
        .saida_pronta   (saida_pronta),
        .descartes      (descartes)
    );

    task automatic chk(input string nome, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", nome, act, exp);
        end
    endtask

    // Monitor: every output transfer pops the channel's expected byte.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            for (int k = 0; k < 8; k++) begin
                if (saida_valida[k] && saida_pronta[k]) begin
                    if (expq[k].size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL ch%0d_unexpected got=%0h expected=none", k, saidas[k*8 +: 8]);
                    end else begin
                        chk($sformatf("ch%0d_data", k), 64'(saidas[k*8 +: 8]), 64'(expq[k].pop_front()));
                    end
                end
            end
        end
    end

    // Presents one byte, waits (bounded) for acceptance, records expectation.
    task automatic send(input logic [7:0] d, input logic [2:0] s, output int espera);
        entrada        = d;
        seletor        = s;
        entrada_valida = 1'b1;
        espera         = 0;
        forever begin
            @(negedge clk);
            if (entrada_pronta) break;
            espera++;
            if (espera > 50) begin
                checks++;
                failures++;
                $display("FAIL send_timeout got=stalled expected=accepted");
                break;
            end
        end
        if (espera <= 50 && habilita[s]) expq[s].push_back(d);
        @(posedge clk);
        #1;
        entrada_valida = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        for (int k = 0; k < 8; k++) expq[k].delete();
        rst_n = 1'b1;
    endtask

    int w;

    initial begin
        entrada        = '0;
        seletor        = '0;
        entrada_valida = 1'b0;
        habilita       = 8'hFF;
        saida_pronta   = 8'hFF;
        do_reset();

        // reset / idle state
        @(negedge clk);
        chk("rst_valida", 64'(saida_valida), 64'h00);
        chk("rst_saidas", saidas, 64'h0);
        chk("rst_descartes", 64'(descartes), 64'h0);
        chk("rst_pronta", 64'(entrada_pronta), 64'h1);
        @(posedge clk); #1;

        // single byte to ch3, one-cycle latency
        send(8'hA5, 3'd3, w);
        chk("a5_wait", 64'(w), 64'h0);
        @(negedge clk);
        chk("a5_valida", 64'(saida_valida), 64'h08);
        chk("a5_byte", 64'(saidas[31:24]), 64'hA5);
        chk("a5_others", saidas & ~64'hFF00_0000, 64'h0);
        @(posedge clk); #1;

        // ch2 stalled: second byte must wait
        saida_pronta = 8'hFB;
        send(8'h11, 3'd2, w);
        entrada = 8'h22; seletor = 3'd2; entrada_valida = 1'b1;
        @(negedge clk);
        chk("stall_pronta", 64'(entrada_pronta), 64'h0);
        chk("stall_hold", 64'(saidas[23:16]), 64'h11);
        @(posedge clk); #1;
        entrada_valida = 1'b0;
        @(negedge clk);
        chk("stall_hold2", 64'(saidas[23:16]), 64'h11);
        chk("stall_valida", 64'(saida_valida[2]), 64'h1);
        @(posedge clk); #1;

        // other channel unaffected by the stall
        send(8'h33, 3'd5, w);
        chk("ch5_wait", 64'(w), 64'h0);
        @(negedge clk);
        chk("ch5_valida", 64'(saida_valida[5]), 64'h1);
        chk("ch5_byte", 64'(saidas[47:40]), 64'h33);
        @(posedge clk); #1;

        // release ch2: 0x11 then 0x22 in order
        saida_pronta = 8'hFF;
        send(8'h22, 3'd2, w);
        repeat (3) @(posedge clk);
        #1;
        chk("ch2_drained", 64'(expq[2].size()), 64'h0);

        // disabled ch0: everything dropped, counter saturates
        habilita = 8'hFE;
        for (int i = 0; i < 100; i++) send(8'(i), 3'd0, w);
        @(negedge clk);
        chk("desc_100", 64'(descartes), 64'd100);
        @(posedge clk); #1;
        for (int i = 100; i < 300; i++) send(8'(i), 3'd0, w);
        @(negedge clk);
        chk("desc_sat", 64'(descartes), 64'd255);
        chk("ch0_never", 64'(saida_valida[0]), 64'h0);
        @(posedge clk); #1;
        habilita = 8'hFF;

        // pass-through on ch4 then reset mid-operation
        send(8'h77, 3'd4, w);
        send(8'h5A, 3'd4, w);
        rst_n = 1'b0;
        @(negedge clk);
        chk("pt_valida", 64'(saida_valida[4]), 64'h1);
        chk("pt_byte", 64'(saidas[39:32]), 64'h5A);
        @(posedge clk); #1;
        for (int k = 0; k < 8; k++) expq[k].delete();
        @(negedge clk);
        chk("rst2_valida", 64'(saida_valida), 64'h00);
        chk("rst2_saidas", saidas, 64'h0);
        chk("rst2_descartes", 64'(descartes), 64'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // traffic resumes after reset
        send(8'hC3, 3'd7, w);
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 8; k++)
            chk($sformatf("final_q%0d", k), 64'(expq[k].size()), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
